// File: rtl/dma_region_guard.sv
// -----------------------------------------------------------------------------
// dma_region_guard
//   Multi-region DMA kill logic that sits beside the openMSP430 core.
//
//   The guard requests a core reset in two cases:
//     - DMA is active while the CPU executes from secure ROM.
//     - DMA touches any of the protected address windows, whatever the CPU is
//       doing.
//
//   Once tripped, the guard holds reset for at least KILL_HOLD quiet cycles.
//   After that it waits until the CPU pc reaches RESET_HANDLER, and only then
//   re-arms. Sticky per-source flags and a saturating event counter record what
//   happened.
//
// Ports
//   mclk        in   system clock
//   reset_n     in   asynchronous active-low reset
//   pc          in   CPU program counter
//   dma_addr    in   DMA address
//   dma_en      in   DMA access valid this cycle
//   clr_stat    in   synchronous clear of viol_flags / viol_cnt
//   reset       out  kill/reset request to the core (active high)
//   pc_in_rom   out  pc lies inside the secure ROM window
//   viol_flags  out  sticky: bit0 = DMA during ROM execution,
//                    bit i+1 = DMA hit region i
//   viol_cnt    out  saturating count of RUN->KILL transitions
// -----------------------------------------------------------------------------
module dma_region_guard #(
  parameter logic [15:0]               SMEM_BASE     = 16'hA000,
  parameter logic [15:0]               SMEM_SIZE     = 16'h4000,
  parameter int                        NUM_REGIONS   = 2,
  parameter logic [16*NUM_REGIONS-1:0] REGION_BASE   = {16'h0200, 16'h6A00},
  parameter logic [16*NUM_REGIONS-1:0] REGION_LAST   = {16'h02FF, 16'h6A3F},
  parameter logic [15:0]               RESET_HANDLER = 16'h0000,
  parameter int                        KILL_HOLD     = 4,
  parameter int                        CNT_W         = 8
) (
  input  logic                   mclk,
  input  logic                   reset_n,
  input  logic [15:0]            pc,
  input  logic [15:0]            dma_addr,
  input  logic                   dma_en,
  input  logic                   clr_stat,
  output logic                   reset,
  output logic                   pc_in_rom,
  output logic [NUM_REGIONS:0]   viol_flags,
  output logic [CNT_W-1:0]       viol_cnt
);

  localparam logic [15:0]       SMEM_LAST   = SMEM_BASE + SMEM_SIZE - 16'd2;
  localparam int                HOLD_W      = (KILL_HOLD > 1) ? $clog2(KILL_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(KILL_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_KILL = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                w_kill_event;

  logic [NUM_REGIONS:0] r_viol_flags;
  logic [CNT_W-1:0]     r_viol_cnt;

  logic [NUM_REGIONS-1:0] w_hit;
  logic                   w_pc_in_rom;
  logic                   w_rom_viol;
  logic                   w_invalid;

  // ---------------------------------------------------------------------------
  // Violation detection (combinational, zero latency)
  // ---------------------------------------------------------------------------
  assign w_pc_in_rom = (pc >= SMEM_BASE) && (pc <= SMEM_LAST);
  assign w_rom_viol  = dma_en & w_pc_in_rom;

  // A region whose last address is below its base can never satisfy both
  // compares, so such a region is disabled without any extra logic.
  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
    assign w_hit[gi] = dma_en
                     & (dma_addr >= REGION_BASE[16*gi +: 16])
                     & (dma_addr <= REGION_LAST[16*gi +: 16]);
  end

  assign w_invalid = w_rom_viol | (|w_hit);

  // ---------------------------------------------------------------------------
  // Kill / wait / run sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_kill_event = 1'b0;
    case (r_state)
      S_KILL: begin
        if (w_invalid) begin
          w_hold_nxt = HOLD_RELOAD;
        end else if (r_hold_cnt == '0) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_hold_nxt = r_hold_cnt - 1'b1;
        end
      end
      S_WAIT: begin
        // A violation always wins over the re-arm pc.
        if (w_invalid) begin
          w_state_nxt = S_KILL;
          w_hold_nxt  = HOLD_RELOAD;
        end else if (pc == RESET_HANDLER) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_invalid) begin
          w_state_nxt  = S_KILL;
          w_hold_nxt   = HOLD_RELOAD;
          w_kill_event = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_KILL;
        w_hold_nxt  = HOLD_RELOAD;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_KILL;
      r_hold_cnt <= HOLD_RELOAD;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status: a set in the same cycle as clr_stat survives the clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_viol_flags <= '0;
      r_viol_cnt   <= '0;
    end else begin
      r_viol_flags <= (clr_stat ? '0 : r_viol_flags) | {w_hit, w_rom_viol};
      if (clr_stat) begin
        r_viol_cnt <= w_kill_event ? CNT_W'(1) : '0;
      end else if (w_kill_event && (r_viol_cnt != CNT_MAX)) begin
        r_viol_cnt <= r_viol_cnt + CNT_W'(1);
      end
    end
  end

  // The registered state keeps reset high after the violating cycle; the
  // invalid term gives the same-cycle kill.
  assign reset      = (r_state != S_RUN) | w_invalid;
  assign pc_in_rom  = w_pc_in_rom;
  assign viol_flags = r_viol_flags;
  assign viol_cnt   = r_viol_cnt;

endmodule

// File: tb/tb_dma_region_guard.sv
// -----------------------------------------------------------------------------
// tb_dma_region_guard
//   Directed scenarios followed by randomized traffic for dma_region_guard.
//   A behavioural model predicts every cycle's outputs and queues them; a
//   monitor on the falling clock edge pops each prediction and compares it
//   with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_dma_region_guard;

  localparam int KILL_HOLD = 4;

  logic        mclk;
  logic        reset_n;
  logic [15:0] pc;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic        clr_stat;
  logic        reset;
  logic        pc_in_rom;
  logic [2:0]  viol_flags;
  logic [7:0]  viol_cnt;

  dma_region_guard dut (
    .mclk       (mclk),
    .reset_n    (reset_n),
    .pc         (pc),
    .dma_addr   (dma_addr),
    .dma_en     (dma_en),
    .clr_stat   (clr_stat),
    .reset      (reset),
    .pc_in_rom  (pc_in_rom),
    .viol_flags (viol_flags),
    .viol_cnt   (viol_cnt)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic       rst;
    logic       rom;
    logic [2:0] flags;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Behavioural model: the guard is either armed or not. When not armed it
  // counts consecutive quiet cycles; once KILL_HOLD of them have passed, a
  // quiet cycle with pc at the reset handler arms it again.
  bit          m_armed;
  int          m_quiet;
  logic [2:0]  m_flags;
  int          m_cnt;
  logic [15:0] rb [2] = '{16'h6A00, 16'h0200};
  logic [15:0] rl [2] = '{16'h6A3F, 16'h02FF};

  task automatic model_reset();
    m_armed = 1'b0;
    m_quiet = 0;
    m_flags = 3'b000;
    m_cnt   = 0;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge mclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("reset",      int'(reset),      int'(e.rst));
      chk("pc_in_rom",  int'(pc_in_rom),  int'(e.rom));
      chk("viol_flags", int'(viol_flags), int'(e.flags));
      chk("viol_cnt",   int'(viol_cnt),   int'(e.cnt));
    end
  end

  // Drive one cycle's inputs (called just after a rising edge), queue the
  // predicted outputs, advance the model and move to the next cycle.
  task automatic cycle(input logic [15:0] i_pc, input logic i_en,
                       input logic [15:0] i_addr, input logic i_clr);
    exp_t       e;
    bit         rom, inv, ev;
    logic [2:0] setb;
    pc       = i_pc;
    dma_en   = i_en;
    dma_addr = i_addr;
    clr_stat = i_clr;
    rom  = (i_pc >= 16'hA000) && (i_pc <= 16'hDFFE);
    setb = 3'b000;
    setb[0] = i_en && rom;
    for (int r = 0; r < 2; r++)
      setb[r+1] = i_en && (i_addr >= rb[r]) && (i_addr <= rl[r]);
    inv = |setb;
    e.rst   = !m_armed || inv;
    e.rom   = rom;
    e.flags = m_flags;
    e.cnt   = 8'(m_cnt);
    exp_q.push_back(e);
    ev = m_armed && inv;
    m_flags = (i_clr ? 3'b000 : m_flags) | setb;
    if (i_clr) m_cnt = ev ? 1 : 0;
    else if (ev && m_cnt < 255) m_cnt = m_cnt + 1;
    if (inv) begin
      m_armed = 1'b0;
      m_quiet = 0;
    end else if (!m_armed) begin
      if (m_quiet >= KILL_HOLD && i_pc == 16'h0000) m_armed = 1'b1;
      else if (m_quiet < 1000) m_quiet = m_quiet + 1;
    end
    @(posedge mclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle; the reset state is checked while
  // reset_n is low.
  task automatic apply_reset();
    exp_t e;
    pc       = 16'h0000;
    dma_en   = 1'b0;
    dma_addr = 16'h0000;
    clr_stat = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    e.rst = 1'b1; e.rom = 1'b0; e.flags = 3'b000; e.cnt = 8'h00;
    exp_q.push_back(e);
    @(posedge mclk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_pc();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hA000 + 16'(($urandom % 16'h2000) * 2);
      2:       return 16'h9FFE;
      3:       return ($urandom_range(0, 1) != 0) ? 16'hDFFE : 16'hE000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] pick [8] = '{16'h01FF, 16'h0200, 16'h02FF, 16'h0300,
                              16'h69FF, 16'h6A00, 16'h6A3F, 16'h6A40};
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return pick[$urandom_range(0, 7)];
  endfunction

  initial begin
    pc = '0; dma_addr = '0; dma_en = 1'b0; clr_stat = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(posedge mclk);
    #1;

    // Reset release, hold, wait and re-arm.
    apply_reset();
    idle(7);

    // DMA while executing from secure ROM.
    cycle(16'hA010, 1'b1, 16'h0000, 1'b0);
    idle(8);

    // Region 0 last address hits, one past it does not.
    cycle(16'h4400, 1'b1, 16'h6A3F, 1'b0);
    idle(6);
    cycle(16'h4400, 1'b1, 16'h6A40, 1'b0);
    idle(2);

    // Violation in KILL with one hold cycle left reloads the hold.
    cycle(16'h4400, 1'b1, 16'h6A3F, 1'b0);
    cycle(16'h4400, 1'b0, 16'h0000, 1'b0);
    cycle(16'h4400, 1'b0, 16'h0000, 1'b0);
    cycle(16'h0000, 1'b1, 16'h0200, 1'b0);
    idle(8);

    // Violation in WAIT together with the re-arm pc.
    cycle(16'h4400, 1'b1, 16'h6A00, 1'b0);
    for (int k = 0; k < 4; k++) cycle(16'h4400, 1'b0, 16'h0000, 1'b0);
    cycle(16'h0000, 1'b1, 16'h0250, 1'b0);
    idle(7);

    // Counter saturation, then clear together with a violation.
    for (int k = 0; k < 260; k++) begin
      cycle(16'h4400, 1'b1, 16'h6A10, 1'b0);
      idle(5);
    end
    cycle(16'h4400, 1'b1, 16'h6A10, 1'b1);
    idle(6);
    cycle(16'h0000, 1'b0, 16'h0000, 1'b1);
    idle(2);

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) apply_reset();
      cycle(rand_pc(),
            ($urandom_range(0, 3) == 0),
            rand_addr(),
            ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of a hold.
    idle(8);
    cycle(16'h4400, 1'b1, 16'h0200, 1'b0);
    idle(1);
    apply_reset();
    idle(7);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge mclk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
